// File: rtl/max_pool_2x2_if.sv
`default_nettype none
// ============================================================================
//  Module      : max_pool_2x2_if
//  Description : Pixel-stream bundle between the CNN convolution core and the
//                2x2 pooling stage. The "master" side drives the stream and
//                frame sizes; the "slave" side is the pooling block.
//                Optional macro POOL_AVG_EN adds the pool_mode select.
//  Revision    : 1.0 - initial release
// ============================================================================
interface max_pool_2x2_if #(
    parameter int PIXEL_WIDTH   = 8,
    parameter int BUFFER_LENGTH = 2000
);
    localparam int c_CNT_W = $clog2(BUFFER_LENGTH);

    logic [PIXEL_WIDTH-1:0] in_pixel;
    logic                   valid_in;
    logic [c_CNT_W-1:0]     frame_column_size;
    logic [c_CNT_W-1:0]     frame_row_size;
`ifdef POOL_AVG_EN
    logic                   pool_mode;
`endif
    logic [PIXEL_WIDTH-1:0] pool_res;
    logic                   valid_out;
    logic                   frame_done;

`ifdef POOL_AVG_EN
    modport master (
        output in_pixel, valid_in, frame_column_size, frame_row_size, pool_mode,
        input  pool_res, valid_out, frame_done
    );
    modport slave (
        input  in_pixel, valid_in, frame_column_size, frame_row_size, pool_mode,
        output pool_res, valid_out, frame_done
    );
`else
    modport master (
        output in_pixel, valid_in, frame_column_size, frame_row_size,
        input  pool_res, valid_out, frame_done
    );
    modport slave (
        input  in_pixel, valid_in, frame_column_size, frame_row_size,
        output pool_res, valid_out, frame_done
    );
`endif
endinterface

`default_nettype wire

// File: rtl/max_pool_2x2.sv
`default_nettype none
// ============================================================================
//  Module      : max_pool_2x2
//  Description : Streaming 2x2 / stride-2 pooling stage. Consumes a raster
//                pixel stream (one pixel per valid beat, no backpressure) and
//                emits one pooled pixel per completed 2x2 window, one cycle
//                after the beat that completes it. Pair results of each even
//                row are parked in a half-width line buffer until the matching
//                odd row arrives.
//                Optional macro POOL_AVG_EN: adds pool_mode (latched per
//                frame) selecting max (0) or truncating average (1) pooling.
//  Revision    : 1.0 - initial release
// ============================================================================
module max_pool_2x2 #(
    parameter int PIXEL_WIDTH   = 8,
    parameter int BUFFER_LENGTH = 2000
) (
    input  logic          clk,
    input  logic          rst,
    max_pool_2x2_if.slave bus
);

    localparam int c_CNT_W  = $clog2(BUFFER_LENGTH);
    localparam int c_ADDR_W = c_CNT_W - 1;
    localparam int c_DEPTH  = BUFFER_LENGTH / 2;
`ifdef POOL_AVG_EN
    // Average mode parks a pair sum, which needs one extra bit.
    localparam int c_BUF_W  = PIXEL_WIDTH + 1;
`else
    localparam int c_BUF_W  = PIXEL_WIDTH;
`endif

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_CNT_W-1:0]     r_cnt_col;
    logic [c_CNT_W-1:0]     r_cnt_row;
    logic [c_CNT_W-1:0]     r_cols_m1;      // latched column count minus one
    logic [c_CNT_W-1:0]     r_rows_m1;      // latched row count minus one
    logic [PIXEL_WIDTH-1:0] r_prev_pixel;
    logic [PIXEL_WIDTH-1:0] r_pool_res;
    logic                   r_valid_out;
    logic                   r_frame_done;
    logic [c_BUF_W-1:0]     r_line_buf [c_DEPTH];
`ifdef POOL_AVG_EN
    logic                   r_pool_mode;
`endif

    // ------------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------------
    logic                   w_first_beat;
    logic [c_CNT_W-1:0]     w_cols_m1;
    logic [c_CNT_W-1:0]     w_rows_m1;
    logic                   w_col_last;
    logic                   w_row_last;
    logic                   w_col_odd;
    logic                   w_row_odd;
    logic [c_ADDR_W-1:0]    w_addr;
    logic                   w_buf_we;
    logic [c_BUF_W-1:0]     w_buf_rd;
    logic [c_BUF_W-1:0]     w_buf_wr;
    logic [PIXEL_WIDTH-1:0] w_buf_max;
    logic [PIXEL_WIDTH-1:0] w_pair_max;
    logic [PIXEL_WIDTH-1:0] w_quad_max;
    logic [PIXEL_WIDTH-1:0] w_pool_val;

    // A zero size is treated as one so the counters still walk a frame.
    function automatic logic [c_CNT_W-1:0] f_size_m1(input logic [c_CNT_W-1:0] size);
        return (size == '0) ? '0 : size - 1'b1;
    endfunction

    // Both counters at zero only ever happens on pixel (0,0) of a frame, so
    // that beat uses the live size inputs; every later beat uses the latch.
    assign w_first_beat = (r_cnt_col == '0) && (r_cnt_row == '0);
    assign w_cols_m1    = w_first_beat ? f_size_m1(bus.frame_column_size) : r_cols_m1;
    assign w_rows_m1    = w_first_beat ? f_size_m1(bus.frame_row_size)    : r_rows_m1;
    assign w_col_last   = (r_cnt_col == w_cols_m1);
    assign w_row_last   = (r_cnt_row == w_rows_m1);
    assign w_col_odd    = r_cnt_col[0];
    assign w_row_odd    = r_cnt_row[0];

    // One buffer slot per column pair; even rows write, odd rows read.
    assign w_addr       = r_cnt_col[c_CNT_W-1:1];
    assign w_buf_we     = bus.valid_in && !rst && !w_row_odd && w_col_odd;
    assign w_buf_rd     = r_line_buf[w_addr];
    assign w_buf_max    = w_buf_rd[PIXEL_WIDTH-1:0];

    assign w_pair_max   = (r_prev_pixel > bus.in_pixel) ? r_prev_pixel : bus.in_pixel;
    assign w_quad_max   = (w_buf_max > w_pair_max) ? w_buf_max : w_pair_max;

`ifdef POOL_AVG_EN
    logic                   w_mode;
    logic [PIXEL_WIDTH:0]   w_pair_sum;
    logic [PIXEL_WIDTH+1:0] w_quad_sum;
    logic [PIXEL_WIDTH-1:0] w_avg;

    assign w_mode     = w_first_beat ? bus.pool_mode : r_pool_mode;
    assign w_pair_sum = {1'b0, r_prev_pixel} + {1'b0, bus.in_pixel};
    assign w_quad_sum = {1'b0, w_buf_rd} + {1'b0, w_pair_sum};
    // Truncating divide by four: simply drop the two LSBs.
    assign w_avg      = PIXEL_WIDTH'(w_quad_sum >> 2);
    assign w_buf_wr   = w_mode ? w_pair_sum : {1'b0, w_pair_max};
    assign w_pool_val = w_mode ? w_avg : w_quad_max;
`else
    assign w_buf_wr   = w_pair_max;
    assign w_pool_val = w_quad_max;
`endif

    // ------------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------------

    // Raster position: column wraps into row, row wraps at end of frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_col <= '0;
            r_cnt_row <= '0;
        end else if (bus.valid_in) begin
            if (w_col_last) begin
                r_cnt_col <= '0;
                r_cnt_row <= w_row_last ? '0 : r_cnt_row + 1'b1;
            end else begin
                r_cnt_col <= r_cnt_col + 1'b1;
            end
        end
    end

    // Frame geometry (and mode) captured on the first beat of each frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cols_m1   <= '0;
            r_rows_m1   <= '0;
`ifdef POOL_AVG_EN
            r_pool_mode <= 1'b0;
`endif
        end else if (bus.valid_in && w_first_beat) begin
            r_cols_m1   <= w_cols_m1;
            r_rows_m1   <= w_rows_m1;
`ifdef POOL_AVG_EN
            r_pool_mode <= w_mode;
`endif
        end
    end

    // Line buffer: contents are don't-care across reset, so no clear.
    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            r_line_buf[w_addr] <= w_buf_wr;
        end
    end

    // Previous pixel, pooled result and single-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_pixel <= '0;
            r_pool_res   <= '0;
            r_valid_out  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_valid_out  <= 1'b0;
            r_frame_done <= 1'b0;
            if (bus.valid_in) begin
                r_prev_pixel <= bus.in_pixel;
                // An odd column in an odd row closes a 2x2 window; trailing
                // odd-sized columns/rows are even-indexed and never land here.
                if (w_row_odd && w_col_odd) begin
                    r_pool_res  <= w_pool_val;
                    r_valid_out <= 1'b1;
                end
                if (w_col_last && w_row_last) begin
                    r_frame_done <= 1'b1;
                end
            end
        end
    end

    assign bus.pool_res   = r_pool_res;
    assign bus.valid_out  = r_valid_out;
    assign bus.frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_max_pool_2x2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_max_pool_2x2
//  Description : Self-checking bench for max_pool_2x2. Directed frames use
//                hand-derived expectations; randomized frames are checked
//                against a window-by-window reference model.
//                Optional macro POOL_AVG_EN enables the average-mode cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_max_pool_2x2;

    localparam int PW = 8;
    localparam int BL = 2000;
    localparam int CW = $clog2(BL);

    logic        clk = 1'b0;
    logic        rst;
    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;
    bit          cur_mode = 1'b0;

    logic [PW-1:0] frame_q[$];
    int unsigned   beat_cyc[$];
    logic [PW-1:0] obs_val[$];
    int unsigned   obs_cyc[$];
    int unsigned   done_cyc[$];
    logic [PW-1:0] exp_val[$];
    int            exp_idx[$];

    max_pool_2x2_if #(.PIXEL_WIDTH(PW), .BUFFER_LENGTH(BL)) bus ();

    max_pool_2x2 #(.PIXEL_WIDTH(PW), .BUFFER_LENGTH(BL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every output pulse with the cycle it was seen in.
    always @(negedge clk) begin
        if (bus.valid_out === 1'b1) begin
            obs_val.push_back(bus.pool_res);
            obs_cyc.push_back(cyc);
        end
        if (bus.frame_done === 1'b1) done_cyc.push_back(cyc);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no summary, want summary");
        $fatal(1);
    end

    task automatic clear_obs();
        obs_val.delete(); obs_cyc.delete(); done_cyc.delete(); beat_cyc.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Drive frame_q as one frame. gap<0 means random 0..2 idle cycles per beat;
    // scramble garbles the size/mode inputs after the first beat.
    task automatic drive_frame(input int cols, input int rows, input int gap, input bit scramble);
        int g;
        bus.frame_column_size = CW'(cols);
        bus.frame_row_size    = CW'(rows);
`ifdef POOL_AVG_EN
        bus.pool_mode         = cur_mode;
`endif
        foreach (frame_q[i]) begin
            bus.in_pixel = frame_q[i];
            bus.valid_in = 1'b1;
            @(posedge clk); #1;
            beat_cyc.push_back(cyc);
            bus.valid_in = 1'b0;
            bus.in_pixel = PW'($urandom);
            if (scramble) begin
                bus.frame_column_size = CW'($urandom_range(0, 15));
                bus.frame_row_size    = CW'($urandom_range(0, 15));
`ifdef POOL_AVG_EN
                bus.pool_mode         = ~cur_mode;
`endif
            end
            @(negedge clk);
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            repeat (g) @(negedge clk);
        end
    endtask

    // Reference: pool every complete 2x2 window of frame_q in raster order.
    function automatic void model(input int cols, input int rows);
        int c, r, top, bot, m, s;
        int p[4];
        c = (cols == 0) ? 1 : cols;
        r = (rows == 0) ? 1 : rows;
        exp_val.delete(); exp_idx.delete();
        for (int pr = 0; pr < r / 2; pr++) begin
            for (int pc = 0; pc < c / 2; pc++) begin
                top = 2 * pr * c + 2 * pc;
                bot = top + c;
                p[0] = frame_q[top]; p[1] = frame_q[top + 1];
                p[2] = frame_q[bot]; p[3] = frame_q[bot + 1];
                m = 0; s = 0;
                for (int k = 0; k < 4; k++) begin
                    s += p[k];
                    if (p[k] > m) m = p[k];
                end
                exp_val.push_back(cur_mode ? PW'(s / 4) : PW'(m));
                exp_idx.push_back(bot + 1);
            end
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (bus.pool_res !== 8'd0) begin fails++; $display("FAIL reset_pool_res: got %0d want 0", bus.pool_res); end
        tests++; if (bus.valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid_out: got %b want 0", bus.valid_out); end
        tests++; if (bus.frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done: got %b want 0", bus.frame_done); end
        #1 rst = 1'b0;
        idle(2);
    endtask

    task automatic test_4x4_continuous();
        clear_obs();
        frame_q.delete();
        for (int i = 0; i < 16; i++) frame_q.push_back(PW'(i));
        drive_frame(4, 4, 0, 1'b1);
        idle(2);
        exp_val = '{8'd5, 8'd7, 8'd13, 8'd15};
        exp_idx = '{5, 7, 13, 15};
        tests++;
        if (obs_val.size() != exp_val.size()) begin fails++; $display("FAIL 4x4_count: got %0d want %0d", obs_val.size(), exp_val.size()); end
        for (int i = 0; i < exp_val.size() && i < obs_val.size(); i++) begin
            tests++;
            if (obs_val[i] !== exp_val[i] || obs_cyc[i] != beat_cyc[exp_idx[i]]) begin
                fails++; $display("FAIL 4x4_out%0d: got %0d@%0d want %0d@%0d", i, obs_val[i], obs_cyc[i], exp_val[i], beat_cyc[exp_idx[i]]);
            end
        end
        tests++;
        if (done_cyc.size() != 1 || done_cyc[0] != beat_cyc[15]) begin fails++; $display("FAIL 4x4_done: got %0d pulses want 1 at %0d", done_cyc.size(), beat_cyc[15]); end
    endtask

    task automatic test_5x5_gapped();
        clear_obs();
        frame_q.delete();
        for (int i = 0; i < 25; i++) frame_q.push_back(PW'(i));
        drive_frame(5, 5, 1, 1'b1);
        idle(2);
        exp_val = '{8'd6, 8'd8, 8'd16, 8'd18};
        exp_idx = '{6, 8, 16, 18};
        tests++;
        if (obs_val.size() != exp_val.size()) begin fails++; $display("FAIL 5x5_count: got %0d want %0d", obs_val.size(), exp_val.size()); end
        for (int i = 0; i < exp_val.size() && i < obs_val.size(); i++) begin
            tests++;
            if (obs_val[i] !== exp_val[i] || obs_cyc[i] != beat_cyc[exp_idx[i]]) begin
                fails++; $display("FAIL 5x5_out%0d: got %0d@%0d want %0d@%0d", i, obs_val[i], obs_cyc[i], exp_val[i], beat_cyc[exp_idx[i]]);
            end
        end
        tests++;
        if (done_cyc.size() != 1 || done_cyc[0] != beat_cyc[24]) begin fails++; $display("FAIL 5x5_done: got %0d pulses want 1 at %0d", done_cyc.size(), beat_cyc[24]); end
    endtask

    task automatic test_back_to_back();
        clear_obs();
        frame_q.delete();
        for (int i = 10; i < 18; i++) frame_q.push_back(PW'(i));
        drive_frame(4, 2, 0, 1'b1);
        frame_q = '{8'd200, 8'd3, 8'd9, 8'd255};
        drive_frame(2, 2, 0, 1'b1);
        idle(2);
        exp_val = '{8'd15, 8'd17, 8'd255};
        exp_idx = '{5, 7, 11};
        tests++;
        if (obs_val.size() != exp_val.size()) begin fails++; $display("FAIL b2b_count: got %0d want %0d", obs_val.size(), exp_val.size()); end
        for (int i = 0; i < exp_val.size() && i < obs_val.size(); i++) begin
            tests++;
            if (obs_val[i] !== exp_val[i] || obs_cyc[i] != beat_cyc[exp_idx[i]]) begin
                fails++; $display("FAIL b2b_out%0d: got %0d@%0d want %0d@%0d", i, obs_val[i], obs_cyc[i], exp_val[i], beat_cyc[exp_idx[i]]);
            end
        end
        tests++;
        if (done_cyc.size() != 2 || done_cyc[0] != beat_cyc[7] || done_cyc[1] != beat_cyc[11]) begin
            fails++; $display("FAIL b2b_done: got %0d pulses want 2 at %0d,%0d", done_cyc.size(), beat_cyc[7], beat_cyc[11]);
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_obs();
        frame_q.delete();
        for (int i = 0; i < 7; i++) frame_q.push_back(PW'(i));
        drive_frame(4, 4, 0, 1'b0);
        idle(1);
        tests++;
        if (obs_val.size() != 1 || obs_val[0] !== 8'd5) begin fails++; $display("FAIL midrst_pre: got %0d outputs want 1 (value 5)", obs_val.size()); end
        clear_obs();
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            tests++;
            if (bus.valid_out !== 1'b0 || bus.pool_res !== 8'd0 || bus.frame_done !== 1'b0) begin
                fails++; $display("FAIL midrst_hold: got res=%0d v=%b d=%b want 0/0/0", bus.pool_res, bus.valid_out, bus.frame_done);
            end
        end
        #1 rst = 1'b0;
        frame_q = '{8'd1, 8'd2, 8'd3, 8'd4};
        drive_frame(2, 2, 0, 1'b0);
        idle(2);
        tests++;
        if (obs_val.size() != 1 || obs_val[0] !== 8'd4 || obs_cyc[0] != beat_cyc[3]) begin
            fails++; $display("FAIL midrst_out: got %0d outputs (first %0d) want 1 output 4 at %0d", obs_val.size(), obs_val[0], beat_cyc[3]);
        end
        tests++;
        if (done_cyc.size() != 1 || done_cyc[0] != beat_cyc[3]) begin fails++; $display("FAIL midrst_done: got %0d pulses want 1 at %0d", done_cyc.size(), beat_cyc[3]); end
    endtask

    task automatic test_degenerate();
        clear_obs();
        frame_q.delete();
        for (int i = 0; i < 8; i++) frame_q.push_back(PW'($urandom));
        drive_frame(8, 1, 0, 1'b1);
        idle(2);
        tests++;
        if (obs_val.size() != 0) begin fails++; $display("FAIL rows1_count: got %0d outputs want 0", obs_val.size()); end
        tests++;
        if (done_cyc.size() != 1 || done_cyc[0] != beat_cyc[7]) begin fails++; $display("FAIL rows1_done: got %0d pulses want 1 at %0d", done_cyc.size(), beat_cyc[7]); end
        clear_obs();
        frame_q = '{8'd9, 8'd250, 8'd17};
        drive_frame(0, 3, 0, 1'b1);
        idle(2);
        tests++;
        if (obs_val.size() != 0) begin fails++; $display("FAIL cols0_count: got %0d outputs want 0", obs_val.size()); end
        tests++;
        if (done_cyc.size() != 1 || done_cyc[0] != beat_cyc[2]) begin fails++; $display("FAIL cols0_done: got %0d pulses want 1 at %0d", done_cyc.size(), beat_cyc[2]); end
    endtask

`ifdef POOL_AVG_EN
    task automatic test_avg();
        for (int m = 1; m >= 0; m--) begin
            clear_obs();
            cur_mode = (m == 1);
            frame_q = '{8'd255, 8'd255, 8'd255, 8'd254};
            drive_frame(2, 2, 0, 1'b1);
            idle(2);
            tests++;
            if (obs_val.size() != 1 || obs_val[0] !== (m == 1 ? 8'd254 : 8'd255) || obs_cyc[0] != beat_cyc[3]) begin
                fails++; $display("FAIL avg_mode%0d: got %0d outputs (first %0d) want 1 output %0d", m, obs_val.size(), obs_val[0], (m == 1) ? 254 : 255);
            end
        end
        cur_mode = 1'b0;
    endtask
`endif

    task automatic test_random();
        int cols, rows, n;
        for (int f = 0; f < 12; f++) begin
            clear_obs();
            cols = $urandom_range(0, 9);
            rows = $urandom_range(0, 9);
`ifdef POOL_AVG_EN
            cur_mode = ($urandom_range(0, 1) == 1);
`endif
            n = ((cols == 0) ? 1 : cols) * ((rows == 0) ? 1 : rows);
            frame_q.delete();
            for (int i = 0; i < n; i++) frame_q.push_back(PW'($urandom));
            model(cols, rows);
            drive_frame(cols, rows, -1, 1'b1);
            idle(2);
            tests++;
            if (obs_val.size() != exp_val.size()) begin fails++; $display("FAIL rand%0d_count: got %0d want %0d (%0dx%0d)", f, obs_val.size(), exp_val.size(), cols, rows); end
            for (int i = 0; i < exp_val.size() && i < obs_val.size(); i++) begin
                tests++;
                if (obs_val[i] !== exp_val[i] || obs_cyc[i] != beat_cyc[exp_idx[i]]) begin
                    fails++; $display("FAIL rand%0d_out%0d: got %0d@%0d want %0d@%0d", f, i, obs_val[i], obs_cyc[i], exp_val[i], beat_cyc[exp_idx[i]]);
                end
            end
            tests++;
            if (done_cyc.size() != 1 || done_cyc[0] != beat_cyc[n - 1]) begin fails++; $display("FAIL rand%0d_done: got %0d pulses want 1 at %0d", f, done_cyc.size(), beat_cyc[n - 1]); end
        end
        cur_mode = 1'b0;
    endtask

    initial begin
        rst                   = 1'b1;
        bus.valid_in          = 1'b0;
        bus.in_pixel          = '0;
        bus.frame_column_size = '0;
        bus.frame_row_size    = '0;
`ifdef POOL_AVG_EN
        bus.pool_mode         = 1'b0;
`endif
        test_reset();
        test_4x4_continuous();
        test_5x5_gapped();
        test_back_to_back();
        test_reset_mid_frame();
        test_degenerate();
`ifdef POOL_AVG_EN
        test_avg();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
